// File: rtl/bin2onehot_pipe.sv
// bin2onehot_pipe: registered binary-to-one-hot decoder behind a two-entry
// elastic buffer (output register plus skid register).
// The index is decoded as it is captured, so each buffer entry holds the
// finished one-hot vector.
// Optional feature macro: BIN2ONEHOT_RANGE_CHECK_EN. When it is defined, each
// entry also stores an err bit for an out-of-range index. When it is not
// defined, err is tied to 0.
module bin2onehot_pipe #(
  parameter int WIDTH_INPUT  = 3,
  parameter int WIDTH_OUTPUT = 8
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [WIDTH_INPUT-1:0]  bin,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [WIDTH_OUTPUT-1:0] onehot,
  output logic                    err,
  output logic [1:0]              count
);

`ifdef BIN2ONEHOT_RANGE_CHECK_EN
  localparam int ERR_W = 1;
`else
  localparam int ERR_W = 0;
`endif
  localparam int ENTRY_W = WIDTH_OUTPUT + ERR_W;

  // The occupancy state doubles as the count output.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t state, state_next;

  logic [ENTRY_W-1:0]      out_q, out_d;
  logic [ENTRY_W-1:0]      skid_q, skid_d;
  logic                    in_ready_q;
  logic                    in_fire, out_fire;
  logic [WIDTH_OUTPUT-1:0] decoded;
  logic [ENTRY_W-1:0]      decoded_entry;

  // Compare bin against every output position.
  // An out-of-range index matches no position and so decodes to all-zero.
  always_comb begin
    decoded = '0;
    for (int i = 0; i < WIDTH_OUTPUT; i++) begin
      if (bin == WIDTH_INPUT'(i)) begin
        decoded[i] = 1'b1;
      end
    end
  end

`ifdef BIN2ONEHOT_RANGE_CHECK_EN
  logic decoded_err;
  assign decoded_err   = ~|decoded;
  assign decoded_entry = {decoded_err, decoded};
  assign err           = out_q[WIDTH_OUTPUT];
`else
  assign decoded_entry = decoded;
  assign err           = 1'b0;
`endif

  assign in_ready  = in_ready_q;
  assign in_fire   = in_valid & in_ready_q;
  assign out_valid = (state != EMPTY);
  assign out_fire  = out_valid & out_ready;
  assign onehot    = out_q[WIDTH_OUTPUT-1:0];
  assign count     = state;

  // Next occupancy and next buffer contents.
  // An entry that has been drained is cleared, so the outputs read zero
  // whenever out_valid is low.
  always_comb begin
    state_next = state;
    out_d      = out_q;
    skid_d     = skid_q;
    case (state)
      EMPTY: begin
        if (in_fire) begin
          out_d      = decoded_entry;
          state_next = ONE;
        end
      end
      ONE: begin
        if (in_fire && out_fire) begin
          out_d = decoded_entry;
        end else if (in_fire) begin
          skid_d     = decoded_entry;
          state_next = TWO;
        end else if (out_fire) begin
          out_d      = '0;
          state_next = EMPTY;
        end
      end
      TWO: begin
        if (out_fire) begin
          out_d      = skid_q;
          skid_d     = '0;
          state_next = ONE;
        end
      end
      default: begin
        state_next = EMPTY;
        out_d      = '0;
        skid_d     = '0;
      end
    endcase
  end

  // State and buffer registers.
  // in_ready is registered from the next occupancy, so it never depends
  // combinationally on out_ready.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= EMPTY;
      out_q      <= '0;
      skid_q     <= '0;
      in_ready_q <= 1'b1;
    end else begin
      state      <= state_next;
      out_q      <= out_d;
      skid_q     <= skid_d;
      in_ready_q <= (state_next != TWO);
    end
  end

endmodule

// File: doc/bin2onehot_pipe.md
Name: bin2onehot_pipe

Overview:
- Registered binary-to-one-hot decoder with valid/ready handshakes on both sides; inverse of the priority one-hot-to-binary encoder.
- Converts a binary index (e.g. ROB/RS/free-list tag) into a one-hot select or wakeup vector for downstream entry arrays.
- Two-entry elastic buffer (output register plus skid register), so in_ready is a registered signal and full throughput is sustained under backpressure.

Parameters:
- WIDTH_INPUT, 3, width of the binary index input.
- WIDTH_OUTPUT, 8, width of the one-hot output. Legal when WIDTH_OUTPUT <= 2**WIDTH_INPUT.

Ports:
- clock  input  1  single clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  a binary index is presented.
- in_ready  output  1  block accepts an index this cycle; registered.
- bin  input  WIDTH_INPUT  binary index to decode.
- out_valid  output  1  onehot/err hold a decoded result.
- out_ready  input  1  consumer accepts the result this cycle.
- onehot  output  WIDTH_OUTPUT  decoded vector; bit bin set.
- err  output  1  presented index was out of range (see Optional Feature).
- count  output  2  number of buffered results (0..2).

Behaviour:
- Reset (asynchronous, takes effect immediately): out_valid=0, onehot=0, err=0, in_ready=1, count=0, skid entry invalid. Reset mid-transfer discards both buffered entries.
- Transfer definitions: in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- Decode: result = (1 << bin) when bin < WIDTH_OUTPUT, otherwise all-zero. Decode is applied at capture time and stored in the buffer.
- Latency: 1 cycle. An index accepted in cycle N appears on onehot with out_valid=1 in cycle N+1.
- State is the occupancy, equal to count:
  - EMPTY (0): in_fire -> output reg <= decode; go to ONE.
  - ONE (1), in_fire with out_fire: output reg <= decode; stay ONE (full throughput).
  - ONE, in_fire without out_fire: skid <= decode; go to TWO; in_ready=0 next cycle.
  - ONE, out_fire without in_fire: go to EMPTY; onehot and err clear to 0.
  - TWO (2): in_ready=0, so no in_fire is possible. On out_fire: output reg <= skid; go to ONE; in_ready=1 next cycle.
- in_ready = (count != 2), driven from a register.
- Output stability: while out_valid & !out_ready, onehot, err and out_valid hold their values unchanged.
- Order: results leave in acceptance order; no drops, no duplicates.
- Whenever out_valid=0, onehot=0 and err=0.
- in_valid with in_ready=0 has no effect; bin is ignored.

Optional Feature:
- Macro: BIN2ONEHOT_RANGE_CHECK_EN.
- Defined: err is stored per entry and is 1 exactly when the captured bin >= WIDTH_OUTPUT; onehot is all-zero for that entry. err travels with its entry through the skid register.
- Not defined: err is tied to 0 and no per-entry err storage exists. Out-of-range indices still yield an all-zero onehot.
- When WIDTH_OUTPUT == 2**WIDTH_INPUT, err is never set in either build.

Test Plan:
- Reset, then single transfer: assert reset mid-stream -> out_valid=0, onehot=0, count=0, in_ready=1. Then bin=5, in_valid=1 for one cycle with out_ready=1 -> next cycle out_valid=1, onehot=8'b0010_0000, err=0.
- Streaming: bin=0..7 on back-to-back cycles, out_ready=1 -> onehot=8'h01,8'h02,...,8'h80 on consecutive cycles; in_ready stays 1; count stays 1.
- Backpressure: out_ready=0, send bin=2 then bin=6 -> count=2, in_ready=0, onehot holds 8'h04. Raise out_ready -> 8'h04 then 8'h40; in_ready returns to 1 the cycle after the first pop.
- Simultaneous push and pop at count=1: bin=3 in with out_ready=1 -> count stays 1, next onehot=8'h08.
- Range check (WIDTH_OUTPUT=6, macro defined): bin=7 -> onehot=6'b0, err=1. Next bin=1 -> onehot=6'b000010, err=0. With macro undefined, the same stimulus gives err=0 throughout.
- Reset while count=2 -> out_valid=0 and count=0 immediately; buffered entries are never emitted after reset release.
